muxcont_param: RTL and testbench

Parametrised output-port mux controller for the router crossbar: one instance per output port. Each cycle it arbitrates among the input ports whose routed destination equals `PORTID`, locks the winner for the whole packet (until its tail flit transfers), and drives the one-hot crossbar select. It generalises the fixed 5-port controller with:

- a configurable port count;
- separate round-robin pointers for multicast and unicast classes;
- multicast-over-unicast priority with a unicast anti-starvation counter;
- explicit packet locking released by a tail handshake.

---
 rtl/muxcont_param.sv | 150 +++++++++++++++
 tb/tb_muxcont_param.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/muxcont_param.sv
// Output-port mux controller: arbitrates among inputs routed to PORTID and locks the winner until its tail flit.
// Latency: grt is combinational (same cycle as req); sel and busy follow one cycle later.
// Backpressure: a flit transfers only with out_ready; a tail held off by out_ready keeps the lock.
module muxcont_param #(
  parameter int NPORT   = 5,
  parameter int PORTW   = 3,
  parameter int PORTID  = 0,
  parameter int AGEW    = 4,
  parameter int AGE_MAX = 8
) (
  input  logic                   clk,
  input  logic                   rst_,
  input  logic [NPORT*PORTW-1:0] port_vec,
  input  logic [NPORT-1:0]       req,
  input  logic [NPORT-1:0]       mcast,
  input  logic [NPORT-1:0]       tail,
  input  logic                   out_ready,
  output logic [NPORT-1:0]       grt,
  output logic [NPORT-1:0]       sel,
  output logic                   busy
);

  localparam int PTRW = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam logic [AGEW-1:0] AGE_LIM = AGEW'(AGE_MAX);
  localparam logic [AGEW-1:0] AGE_SAT = '1;
  localparam logic [PTRW-1:0] LAST_IDX = PTRW'(NPORT - 1);

  typedef enum logic {S_IDLE, S_LOCKED} state_e;

  state_e           state_q, state_d;
  logic [NPORT-1:0] owner_q, owner_d;
  logic [NPORT-1:0] sel_q;
  logic [PTRW-1:0]  rr_m_q, rr_m_d;
  logic [PTRW-1:0]  rr_u_q, rr_u_d;
  logic [AGEW-1:0]  age_q, age_d;

  logic [NPORT-1:0] match, m_req, u_req, arb;
  logic             use_m, use_u, adopt, owner_live, xfer;
  logic [PTRW-1:0]  arb_idx;

  // Round-robin search: first set bit at or after pointer p, wrapping to 0.
  function automatic logic [PTRW-1:0] rr_pick(input logic [NPORT-1:0] r,
                                               input logic [PTRW-1:0]  p);
    logic [PTRW-1:0] win;
    logic [PTRW-1:0] idx_w;
    int              idx;
    win = '0;
    // Scan from the farthest candidate down so the closest one to p wins last.
    for (int k = NPORT - 1; k >= 0; k--) begin
      idx   = (int'(p) + k) % NPORT;
      idx_w = PTRW'(idx);
      if (r[idx_w]) win = idx_w;
    end
    return win;
  endfunction

  function automatic logic [PTRW-1:0] ptr_next(input logic [PTRW-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + 1'b1;
  endfunction

  // Destination filter: only inputs routed to this output port take part.
  always_comb begin
    match = '0;
    for (int i = 0; i < NPORT; i++) begin
      match[i] = req[i] && (port_vec[i*PORTW +: PORTW] == PORTW'(PORTID));
    end
  end

  // Class selection (multicast first unless unicast has aged out) and round-robin winner.
  always_comb begin
    m_req   = match & mcast;
    u_req   = match & ~mcast;
    use_m   = (|m_req) && (age_q < AGE_LIM);
    use_u   = !use_m && (|u_req);
    arb_idx = use_m ? rr_pick(m_req, rr_m_q) : rr_pick(u_req, rr_u_q);
    arb     = '0;
    if (use_m || use_u) arb[arb_idx] = 1'b1;
  end

  // Grant selection and next-state: lock hold, owner withdrawal, new lock, tail release.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_m_d     = rr_m_q;
    rr_u_d     = rr_u_q;
    age_d      = age_q;
    grt        = '0;
    adopt      = 1'b0;
    owner_live = |(owner_q & match);

    if (state_q == S_LOCKED && owner_live) begin
      grt = owner_q;
    end else begin
      grt   = arb;
      adopt = |arb;
    end

    // Reset drops any lock immediately, so nothing may be granted meanwhile.
    if (rst_) begin
      grt   = '0;
      adopt = 1'b0;
    end

    xfer = (|(grt & match)) && out_ready;

    if (adopt) begin
      state_d = S_LOCKED;
      owner_d = arb;
      if (use_m) begin
        rr_m_d = ptr_next(arb_idx);
        if (|u_req) age_d = (age_q == AGE_SAT) ? age_q : age_q + 1'b1;
      end else begin
        rr_u_d = ptr_next(arb_idx);
        age_d  = '0;
      end
    end else if (state_q == S_LOCKED && !owner_live) begin
      state_d = S_IDLE;
      owner_d = '0;
    end

    // A transferred tail ends the packet and overrides every other transition.
    if (xfer && (|(grt & tail))) begin
      state_d = S_IDLE;
      owner_d = '0;
    end
  end

  // State, pointers, age and the crossbar select register.
  always_ff @(posedge clk) begin
    if (rst_) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      sel_q   <= '0;
      rr_m_q  <= '0;
      rr_u_q  <= '0;
      age_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      sel_q   <= grt;
      rr_m_q  <= rr_m_d;
      rr_u_q  <= rr_u_d;
      age_q   <= age_d;
    end
  end

  assign sel  = sel_q;
  assign busy = (state_q == S_LOCKED);

endmodule

// File: tb/tb_muxcont_param.sv
// Bench for muxcont_param: directed vector table plus random traffic against a reference model.
// Checks grt in the same cycle, and sel/busy as registered one cycle later.
// out_ready is driven directly; random phase toggles it to exercise held tails.
module tb_muxcont_param;

  localparam int N  = 5;
  localparam int PW = 3;
  localparam int AM = 2;
  localparam logic [N*PW-1:0] PVF = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4};

  logic            clk = 1'b0;
  logic            rst_;
  logic [N*PW-1:0] port_vec;
  logic [N-1:0]    req, mcast, tail;
  logic            out_ready;
  logic [N-1:0]    grt, sel;
  logic            busy;

  muxcont_param #(
    .NPORT(N), .PORTW(PW), .PORTID(0), .AGEW(4), .AGE_MAX(AM)
  ) dut (
    .clk(clk), .rst_(rst_), .port_vec(port_vec), .req(req), .mcast(mcast),
    .tail(tail), .out_ready(out_ready), .grt(grt), .sel(sel), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: owner index (-1 = no lock), class pointers, age, expected sel.
  int           m_owner = -1;
  int           m_rrm   = 0;
  int           m_rru   = 0;
  int           m_age   = 0;
  logic [N-1:0] m_sel   = '0;

  typedef struct packed {
    logic            rst;
    logic [N*PW-1:0] pv;
    logic [N-1:0]    rq, mc, tl;
    logic            ordy;
    logic [N-1:0]    eg, es;
    logic            eb;
  } vec_t;

  vec_t tab[$];

  function automatic bit bit_of(input logic [N-1:0] v, input int idx);
    return ((v >> idx) & N'(1)) != '0;
  endfunction

  function automatic int rr_first(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (bit_of(r, (p + k) % N)) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic vec_t mk(input logic rst, input logic [N*PW-1:0] pv,
                              input logic [N-1:0] rq, input logic [N-1:0] mc,
                              input logic [N-1:0] tl, input logic ordy,
                              input logic [N-1:0] eg, input logic [N-1:0] es,
                              input logic eb);
    vec_t v;
    v.rst = rst; v.pv = pv; v.rq = rq; v.mc = mc; v.tl = tl; v.ordy = ordy;
    v.eg = eg; v.es = es; v.eb = eb;
    return v;
  endfunction

  task automatic check(input string name, input int id,
                       input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %b expected %b", name, id, act, exp);
    end
  endtask

  // One clock cycle: compare at negedge, then advance the model and the clock.
  task automatic step(input int id, input bit tabchk, input logic [N-1:0] eg,
                      input logic [N-1:0] es, input logic eb, input bit mchk);
    logic [N-1:0] match, mm, um, g;
    int           arb_i, g_i;
    bit           adopt, use_m, use_u;
    @(negedge clk);
    for (int i = 0; i < N; i++) match[i] = req[i] && (port_vec[i*PW +: PW] == '0);
    mm    = match & mcast;
    um    = match & ~mcast;
    use_m = (mm != '0) && (m_age < AM);
    use_u = !use_m && (um != '0);
    arb_i = use_m ? rr_first(mm, m_rrm) : (use_u ? rr_first(um, m_rru) : -1);
    adopt = 1'b0;
    if (rst_) g_i = -1;
    else if (m_owner >= 0 && bit_of(match, m_owner)) g_i = m_owner;
    else begin
      g_i   = arb_i;
      adopt = (arb_i >= 0);
    end
    g = (g_i >= 0) ? (N'(1) << g_i) : '0;

    check("grt_model", id, grt, g);
    check("grt_onehot", id, N'($countones(grt) <= 1), N'(1));
    check("grt_subset", id, grt & ~match, '0);
    if (mchk) begin
      check("sel_model", id, sel, m_sel);
      check("busy_model", id, N'(busy), N'(m_owner >= 0));
    end
    if (tabchk) begin
      check("grt_vec", id, grt, eg);
      check("sel_vec", id, sel, es);
      check("busy_vec", id, N'(busy), N'(eb));
    end

    if (rst_) begin
      m_owner = -1; m_rrm = 0; m_rru = 0; m_age = 0; m_sel = '0;
    end else begin
      if (adopt) begin
        if (use_m) begin
          m_rrm = (arb_i + 1) % N;
          if (um != '0 && m_age < 15) m_age++;
        end else begin
          m_rru = (arb_i + 1) % N;
          m_age = 0;
        end
      end
      if (g_i >= 0 && out_ready && bit_of(tail, g_i)) m_owner = -1;
      else m_owner = g_i;
      m_sel = g;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_ = 1'b1; port_vec = '0; req = '0; mcast = '0; tail = '0; out_ready = 1'b0;
    step(0, 0, '0, '0, 1'b0, 0);
    step(1, 0, '0, '0, 1'b0, 1);

    //            rst   pv   req       mc        tail      rdy   grt       sel       busy
    // reset state
    tab.push_back(mk(0, '0,  5'b00000, 5'b00000, 5'b00000, 1,   5'b00000, 5'b00000, 0));
    // unicast round-robin 1,3,1 with wrap
    tab.push_back(mk(0, '0,  5'b01010, 5'b00000, 5'b01010, 1,   5'b00010, 5'b00000, 0));
    tab.push_back(mk(0, '0,  5'b01010, 5'b00000, 5'b01010, 1,   5'b01000, 5'b00010, 0));
    tab.push_back(mk(0, '0,  5'b01010, 5'b00000, 5'b01010, 1,   5'b00010, 5'b01000, 0));
    tab.push_back(mk(0, '0,  5'b00000, 5'b00000, 5'b00000, 1,   5'b00000, 5'b00010, 0));
    // 4-flit packet from input 0, out_ready 1,0,1,1,1, input 4 waiting
    tab.push_back(mk(0, '0,  5'b00001, 5'b00000, 5'b00000, 1,   5'b00001, 5'b00000, 0));
    tab.push_back(mk(0, '0,  5'b10001, 5'b00000, 5'b00000, 0,   5'b00001, 5'b00001, 1));
    tab.push_back(mk(0, '0,  5'b10001, 5'b00000, 5'b00000, 1,   5'b00001, 5'b00001, 1));
    tab.push_back(mk(0, '0,  5'b10001, 5'b00000, 5'b00000, 1,   5'b00001, 5'b00001, 1));
    tab.push_back(mk(0, '0,  5'b10001, 5'b00000, 5'b00001, 1,   5'b00001, 5'b00001, 1));
    tab.push_back(mk(0, '0,  5'b10000, 5'b00000, 5'b00000, 1,   5'b10000, 5'b00001, 0));
    tab.push_back(mk(0, '0,  5'b10000, 5'b00000, 5'b10000, 1,   5'b10000, 5'b10000, 1));
    tab.push_back(mk(0, '0,  5'b00000, 5'b00000, 5'b00000, 1,   5'b00000, 5'b10000, 0));
    // multicast 2,3 then aged unicast 1, then multicast again after age clears
    tab.push_back(mk(0, '0,  5'b01110, 5'b01100, 5'b01110, 1,   5'b00100, 5'b00000, 0));
    tab.push_back(mk(0, '0,  5'b01110, 5'b01100, 5'b01110, 1,   5'b01000, 5'b00100, 0));
    tab.push_back(mk(0, '0,  5'b01110, 5'b01100, 5'b01110, 1,   5'b00010, 5'b01000, 0));
    tab.push_back(mk(0, '0,  5'b01110, 5'b01100, 5'b01110, 1,   5'b00100, 5'b00010, 0));
    tab.push_back(mk(0, '0,  5'b00000, 5'b00000, 5'b00000, 1,   5'b00000, 5'b00100, 0));
    // owner withdrawal: input 2 locked, drops, input 0 takes over in the same cycle
    tab.push_back(mk(0, '0,  5'b00100, 5'b00000, 5'b00000, 1,   5'b00100, 5'b00000, 0));
    tab.push_back(mk(0, '0,  5'b00001, 5'b00000, 5'b00000, 1,   5'b00001, 5'b00100, 1));
    tab.push_back(mk(0, '0,  5'b00001, 5'b00000, 5'b00000, 1,   5'b00001, 5'b00001, 1));
    tab.push_back(mk(0, '0,  5'b00000, 5'b00000, 5'b00000, 1,   5'b00000, 5'b00001, 1));
    tab.push_back(mk(0, '0,  5'b00000, 5'b00000, 5'b00000, 1,   5'b00000, 5'b00000, 0));
    // destination filter: only input 4 targets this port
    tab.push_back(mk(0, PVF, 5'b11111, 5'b00000, 5'b00000, 1,   5'b10000, 5'b00000, 0));
    tab.push_back(mk(0, PVF, 5'b11111, 5'b00000, 5'b00000, 1,   5'b10000, 5'b10000, 1));
    // reset mid-packet with input 2 locked; pointers restart at 0 afterwards
    tab.push_back(mk(0, '0,  5'b00100, 5'b00000, 5'b00000, 1,   5'b00100, 5'b10000, 1));
    tab.push_back(mk(1, '0,  5'b00100, 5'b00000, 5'b00000, 1,   5'b00000, 5'b00100, 1));
    tab.push_back(mk(0, '0,  5'b10010, 5'b00000, 5'b10010, 1,   5'b00010, 5'b00000, 0));
    tab.push_back(mk(0, '0,  5'b00000, 5'b00000, 5'b00000, 1,   5'b00000, 5'b00010, 0));

    for (int t = 0; t < tab.size(); t++) begin
      rst_      = tab[t].rst;
      port_vec  = tab[t].pv;
      req       = tab[t].rq;
      mcast     = tab[t].mc;
      tail      = tab[t].tl;
      out_ready = tab[t].ordy;
      step(100 + t, 1, tab[t].eg, tab[t].es, tab[t].eb, 1);
    end

    // Random traffic with mixed destinations, classes, tails and backpressure.
    for (int c = 0; c < 1000; c++) begin
      rst_ = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < N; i++) port_vec[i*PW +: PW] = PW'($urandom_range(0, 2));
      req       = N'($urandom);
      mcast     = N'($urandom);
      tail      = N'($urandom) & N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step(2000 + c, 0, '0, '0, 1'b0, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
